// File: rtl/fft_frame_uart_tx_if.sv
// Signal bundle between the FFT output RAM / frame source and the UART frame sender.
// The sender uses the slave modport; the environment (RAM and FFT side) uses master.
interface fft_frame_uart_tx_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              tx;
    logic              busy;
    logic              frame_done;
    logic              dropped_start;

    modport master (
        output start, ram_data,
        input  ram_addr, tx, busy, frame_done, dropped_start
    );

    modport slave (
        input  start, ram_data,
        output ram_addr, tx, busy, frame_done, dropped_start
    );
endinterface

// File: rtl/fft_frame_uart_tx.sv
// Streams one FFT output frame (sync, big-endian bins, XOR checksum) out of an 8N1 UART.
// The next bin is addressed one byte ahead so the 1-cycle RAM latency is hidden.
module fft_frame_uart_tx #(
    parameter int NUM_BINS     = 128,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                clk,
    input  logic                reset,
    fft_frame_uart_tx_if.slave  bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] BIN_LAST   = ADDR_W'(NUM_BINS - 1);
    localparam logic [7:0]        SYNC0_BYTE = 8'hA5;
    localparam logic [7:0]        SYNC1_BYTE = 8'h5A;

    typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, HI, LO, CKSUM} state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [3:0]        bit_idx;
    logic [7:0]        shift_byte;
    logic [7:0]        hold_lo;
    logic [7:0]        cksum;
    logic [ADDR_W-1:0] bin;
    logic [ADDR_W-1:0] addr_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic              drop_q;
    logic [7:0]        ram_hi;

    assign ram_hi = bus.ram_data[DATA_W-1 -: 8];

    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        drop_q <= bus.start && busy_q;
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            cksum   <= '0;
            bin     <= '0;
            addr_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= SYNC0;
                        busy_q     <= 1'b1;
                        cksum      <= '0;
                        bin        <= '0;
                        addr_q     <= '0;
                        shift_byte <= SYNC0_BYTE;
                        tx_q       <= 1'b0;
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                    end
                end
                default: begin
                    if (bit_cnt != CNT_LAST) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (bit_idx != 4'd9) begin
                        // bit_idx 0 is the start bit, so data bit n follows index n
                        bit_cnt <= '0;
                        bit_idx <= bit_idx + 4'd1;
                        tx_q    <= (bit_idx == 4'd8) ? 1'b1 : shift_byte[bit_idx[2:0]];
                    end else begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_q    <= 1'b0;
                        case (state)
                            SYNC0: begin
                                state      <= SYNC1;
                                shift_byte <= SYNC1_BYTE;
                            end
                            SYNC1, LO: begin
                                if (state == LO && bin == BIN_LAST) begin
                                    state      <= CKSUM;
                                    shift_byte <= cksum;
                                end else begin
                                    state      <= HI;
                                    hold_lo    <= bus.ram_data[7:0];
                                    shift_byte <= ram_hi;
                                    cksum      <= cksum ^ ram_hi;
                                    if (state == LO)
                                        bin <= bin + 1'b1;
                                end
                            end
                            HI: begin
                                state      <= LO;
                                shift_byte <= hold_lo;
                                cksum      <= cksum ^ hold_lo;
                                // present the next bin address a full byte before its capture
                                if (bin != BIN_LAST)
                                    addr_q <= bin + 1'b1;
                            end
                            CKSUM: begin
                                state  <= IDLE;
                                tx_q   <= 1'b1;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                addr_q <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.ram_addr      = addr_q;
    assign bus.tx            = tx_q;
    assign bus.busy          = busy_q;
    assign bus.frame_done    = done_q;
    assign bus.dropped_start = drop_q;
endmodule

// File: tb/tb_fft_frame_uart_tx.sv
// Bench for fft_frame_uart_tx: 4 bins, 4 clocks per bit, a 1-cycle-latency RAM model,
// tx sampled every cycle and decoded at fixed bit positions.
module tb_fft_frame_uart_tx;
    localparam int NB        = 4;
    localparam int CPB       = 4;
    localparam int AW        = 8;
    localparam int DW        = 16;
    localparam int NBYTES    = 3 + 2 * NB;
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = NBYTES * BYTE_CYC;
    localparam int MAXC      = 1024;

    typedef struct packed {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] w3;
        logic [7:0]  ck;
    } vec_t;

    logic    clk = 1'b0;
    logic    reset;
    int      n_cmp = 0;
    int      n_fail = 0;
    logic [DW-1:0] ram [NB];
    logic          tx_s   [MAXC];
    logic          busy_s [MAXC];
    logic [AW-1:0] addr_s [MAXC];
    int            done_at [$];
    int            drop_at [$];

    fft_frame_uart_tx_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fft_frame_uart_tx #(
        .NUM_BINS(NB), .ADDR_W(AW), .DATA_W(DW), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        bus.ram_data <= (int'(bus.ram_addr) < NB) ? ram[bus.ram_addr[1:0]] : 16'hDEAD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    // Runs a fixed number of cycles; start/reset are one-cycle pulses driven at chosen cycles.
    task automatic run(input int ncyc, input int s0, input int s1, input int rst_at);
        done_at.delete();
        drop_at.delete();
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            tx_s[k]   = bus.tx;
            busy_s[k] = bus.busy;
            addr_s[k] = bus.ram_addr;
            if (bus.frame_done)    done_at.push_back(k);
            if (bus.dropped_start) drop_at.push_back(k);
            bus.start = (k == s0) || (k == s1);
            reset     = (k == rst_at);
        end
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic load_ram(input vec_t v);
        ram[0] = v.w0;
        ram[1] = v.w1;
        ram[2] = v.w2;
        ram[3] = v.w3;
    endtask

    task automatic check_frame(input string nm, input int base, input vec_t v);
        logic [7:0] want [NBYTES];
        logic [7:0] got;
        logic       shape_ok;
        int         p;
        want[0] = 8'hA5;      want[1] = 8'h5A;
        want[2] = v.w0[15:8]; want[3] = v.w0[7:0];
        want[4] = v.w1[15:8]; want[5] = v.w1[7:0];
        want[6] = v.w2[15:8]; want[7] = v.w2[7:0];
        want[8] = v.w3[15:8]; want[9] = v.w3[7:0];
        want[10] = v.ck;
        shape_ok = (tx_s[base-1] === 1'b1) && (tx_s[base+FRAME_CYC] === 1'b1);
        got = '0;
        for (int b = 0; b < NBYTES; b++) begin
            for (int i = 0; i < 10; i++) begin
                p = base + b * BYTE_CYC + i * CPB;
                for (int j = 1; j < CPB; j++)
                    if (tx_s[p+j] !== tx_s[p]) shape_ok = 1'b0;
                if (i == 0 && tx_s[p] !== 1'b0) shape_ok = 1'b0;
                if (i == 9 && tx_s[p] !== 1'b1) shape_ok = 1'b0;
                if (i >= 1 && i <= 8) got[i-1] = tx_s[p];
            end
            chk($sformatf("%s byte%0d", nm, b), {24'h0, got}, {24'h0, want[b]});
        end
        chk({nm, " bit timing"}, {31'h0, shape_ok}, 32'h1);
    endtask

    task automatic check_done(input string nm, input int base);
        chk({nm, " frame_done count"}, done_at.size(), 1);
        if (done_at.size() > 0)
            chk({nm, " frame_done cycle"}, done_at[0], base + FRAME_CYC);
    endtask

    initial begin
        vec_t vecs [5];
        vecs[0] = '{16'h1234, 16'hABCD, 16'h00FF, 16'h8001, 8'h3E};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h00};
        vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00};
        vecs[3] = '{16'h0102, 16'h0408, 16'h1020, 16'h4080, 8'hFF};
        vecs[4] = '{16'hA5A5, 16'h5A5A, 16'h0000, 16'h0001, 8'h01};

        bus.start = 1'b0;
        reset     = 1'b1;
        load_ram(vecs[0]);
        repeat (3) @(negedge clk);
        chk("reset tx", {31'h0, bus.tx}, 32'h1);
        chk("reset busy", {31'h0, bus.busy}, 32'h0);
        chk("reset frame_done", {31'h0, bus.frame_done}, 32'h0);
        chk("reset dropped_start", {31'h0, bus.dropped_start}, 32'h0);
        chk("reset ram_addr", {24'h0, bus.ram_addr}, 32'h0);
        reset = 1'b0;

        for (int t = 0; t < 5; t++) begin
            load_ram(vecs[t]);
            run(3 + FRAME_CYC + 8, 2, -1, -1);
            check_frame($sformatf("vec%0d", t), 3, vecs[t]);
            check_done($sformatf("vec%0d", t), 3);
            chk($sformatf("vec%0d busy during", t), {31'h0, busy_s[3]}, 32'h1);
            chk($sformatf("vec%0d busy after", t), {31'h0, busy_s[3+FRAME_CYC]}, 32'h0);
            chk($sformatf("vec%0d addr idle", t), {24'h0, addr_s[3+FRAME_CYC]}, 32'h0);
            chk($sformatf("vec%0d no drop", t), drop_at.size(), 0);
        end

        // second start while busy is reported and ignored
        load_ram(vecs[0]);
        run(3 + FRAME_CYC + 8, 2, 102, -1);
        check_frame("drop", 3, vecs[0]);
        check_done("drop", 3);
        chk("drop count", drop_at.size(), 1);
        if (drop_at.size() > 0)
            chk("drop cycle", drop_at[0], 103);

        // start in the frame_done cycle launches the next frame straight away
        run(4 + 2 * FRAME_CYC + 8, 2, 3 + FRAME_CYC, -1);
        check_frame("b2b first", 3, vecs[0]);
        check_frame("b2b second", 4 + FRAME_CYC, vecs[0]);
        chk("b2b done count", done_at.size(), 2);
        if (done_at.size() == 2) begin
            chk("b2b done0", done_at[0], 3 + FRAME_CYC);
            chk("b2b done1", done_at[1], 4 + 2 * FRAME_CYC);
        end
        chk("b2b busy at done", {31'h0, busy_s[3+FRAME_CYC]}, 32'h0);
        chk("b2b no drop", drop_at.size(), 0);

        // reset in the middle of bin 2's high byte, then a clean frame
        load_ram(vecs[3]);
        run(301 + FRAME_CYC + 8, 2, 300, 3 + 6 * BYTE_CYC + 10);
        chk("rst tx", {31'h0, tx_s[4+6*BYTE_CYC+10]}, 32'h1);
        chk("rst busy", {31'h0, busy_s[4+6*BYTE_CYC+10]}, 32'h0);
        chk("rst addr", {24'h0, addr_s[4+6*BYTE_CYC+10]}, 32'h0);
        check_frame("rst refill", 301, vecs[3]);
        check_done("rst", 301);
        chk("rst no drop", drop_at.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
